indications_ctrl: RTL and testbench

INDICATIONS_CTRL -- requirements
Module: indications_ctrl

---
 rtl/indications_ctrl_pkg.sv | 18 +
 rtl/indications_ctrl_life_icon_rom.sv | 29 ++
 rtl/indications_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_indications_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/indications_ctrl_pkg.sv
// Shared constants, state type and clamp helper for the on-screen life indicator.
package indications_ctrl_pkg;

  localparam int         LIFE_INIT  = 3;
  localparam logic [7:0] COLOR_LIFE = 8'hE0;
  localparam logic [7:0] COLOR_GAIN = 8'h1C;

  typedef enum logic [1:0] {
    STEADY     = 2'd0,
    LOSS_BLINK = 2'd1,
    GAIN_FLASH = 2'd2
  } ind_state_t;

  function automatic logic [3:0] clamp_life(input logic [3:0] v, input logic [3:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/indications_ctrl_life_icon_rom.sv
// 16x16 heart bitmap; x=0 is the leftmost column, y=0 the top row.
module life_icon_rom (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic       pix
);

  logic [15:0] row;

  always_comb begin
    case (y)
      4'd1:    row = 16'h1C38;
      4'd2:    row = 16'h3E7C;
      4'd3:    row = 16'h7FFE;
      4'd4:    row = 16'h7FFE;
      4'd5:    row = 16'h7FFE;
      4'd6:    row = 16'h7FFE;
      4'd7:    row = 16'h3FFC;
      4'd8:    row = 16'h1FF8;
      4'd9:    row = 16'h0FF0;
      4'd10:   row = 16'h07E0;
      4'd11:   row = 16'h03C0;
      4'd12:   row = 16'h0180;
      default: row = 16'h0000;
    endcase
    pix = row[4'd15 - x];
  end

endmodule

// File: rtl/indications_ctrl.sv
// Life-icon overlay with loss blink and optional gain flash (INDICATIONS_GAIN_FLASH_EN).
// Icon state advances once per frame, on the scan position (0,0).
module indications_ctrl
  import indications_ctrl_pkg::*;
#(
  parameter int LIFE_MAX     = 7,
  parameter int TOP_X        = 8,
  parameter int TOP_Y        = 8,
  parameter int ICON_GAP     = 4,
  parameter int BLINK_FRAMES = 32,
  parameter int BLINK_HALF   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic [3:0]  life,
  output logic        drawIndications,
  output logic [7:0]  RGBIndications,
  output logic        animBusy
);

  localparam int            CW       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(BLINK_FRAMES - 1);
  localparam logic [CW-1:0] HALF     = CW'(BLINK_HALF);
  localparam logic [3:0]    LMAX     = 4'(LIFE_MAX);
  localparam logic [3:0]    LINIT    = (LIFE_INIT > LIFE_MAX) ? 4'(LIFE_MAX) : 4'(LIFE_INIT);
  localparam int            PITCH    = 16 + ICON_GAP;

  ind_state_t    state, state_nxt;
  logic [3:0]    life_shown, life_shown_nxt;
  logic [3:0]    loss_from, loss_from_nxt;
  logic [3:0]    loss_to, loss_to_nxt;
  logic [CW-1:0] blink_cnt, blink_cnt_nxt;
`ifdef INDICATIONS_GAIN_FLASH_EN
  logic [3:0]    gain_from, gain_from_nxt;
  logic [3:0]    gain_base;
`endif
  logic          tick;
  logic [3:0]    life_eff;
  logic          do_loss, do_gain;

  assign tick     = (pixelX == 11'd0) && (pixelY == 11'd0);
  assign life_eff = clamp_life(life, LMAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= STEADY;
      life_shown <= LINIT;
      loss_from  <= '0;
      loss_to    <= '0;
      blink_cnt  <= '0;
`ifdef INDICATIONS_GAIN_FLASH_EN
      gain_from  <= '0;
`endif
    end else begin
      state      <= state_nxt;
      life_shown <= life_shown_nxt;
      loss_from  <= loss_from_nxt;
      loss_to    <= loss_to_nxt;
      blink_cnt  <= blink_cnt_nxt;
`ifdef INDICATIONS_GAIN_FLASH_EN
      gain_from  <= gain_from_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt      = state;
    life_shown_nxt = life_shown;
    loss_from_nxt  = loss_from;
    loss_to_nxt    = loss_to;
    blink_cnt_nxt  = blink_cnt;
    do_loss        = 1'b0;
    do_gain        = 1'b0;
`ifdef INDICATIONS_GAIN_FLASH_EN
    gain_from_nxt  = gain_from;
    gain_base      = life_shown;
`endif
    if (tick) begin
      case (state)
        LOSS_BLINK: begin
          // loss_to is the level the blink settles to; lifeShown still holds loss_from
          if (life_eff < loss_to) begin
            loss_to_nxt   = life_eff;
            blink_cnt_nxt = CNT_LOAD;
          end else if (life_eff > loss_to) begin
            do_gain = 1'b1;
`ifdef INDICATIONS_GAIN_FLASH_EN
            gain_base = loss_to;
`endif
          end else if (blink_cnt == '0) begin
            life_shown_nxt = loss_to;
            state_nxt      = STEADY;
          end else begin
            blink_cnt_nxt = blink_cnt - 1'b1;
          end
        end
`ifdef INDICATIONS_GAIN_FLASH_EN
        GAIN_FLASH: begin
          if (life_eff < life_shown)      do_loss = 1'b1;
          else if (life_eff > life_shown) do_gain = 1'b1;
          else if (blink_cnt == '0)       state_nxt = STEADY;
          else                            blink_cnt_nxt = blink_cnt - 1'b1;
        end
`endif
        default: begin
          state_nxt = STEADY;
          if (life_eff < life_shown)      do_loss = 1'b1;
          else if (life_eff > life_shown) do_gain = 1'b1;
        end
      endcase

      if (do_loss) begin
        state_nxt     = LOSS_BLINK;
        loss_from_nxt = life_shown;
        loss_to_nxt   = life_eff;
        blink_cnt_nxt = CNT_LOAD;
      end
      if (do_gain) begin
        life_shown_nxt = life_eff;
`ifdef INDICATIONS_GAIN_FLASH_EN
        state_nxt      = GAIN_FLASH;
        gain_from_nxt  = gain_base;
        blink_cnt_nxt  = CNT_LOAD;
`else
        state_nxt      = STEADY;
        blink_cnt_nxt  = '0;
`endif
      end
    end
  end

  logic [31:0]   px, py, lo;
  logic          x_hit, y_hit, icon_vis, icon_gain, rom_pix, blink_on;
  logic [3:0]    icon_idx, xo, yo;
  logic [CW-1:0] blink_el;
  logic          draw_p0;
  logic [7:0]    rgb_p0;

  assign px = 32'(pixelX);
  assign py = 32'(pixelY);

  always_comb begin
    x_hit    = 1'b0;
    icon_idx = '0;
    xo       = '0;
    lo       = '0;
    for (int i = 0; i < LIFE_MAX; i++) begin
      lo = 32'(TOP_X + i * PITCH);
      if ((px >= lo) && (px < lo + 32'd16)) begin
        x_hit    = 1'b1;
        icon_idx = 4'(i);
        xo       = 4'(px - lo);
      end
    end
  end

  assign y_hit = (py >= 32'(TOP_Y)) && (py < 32'(TOP_Y + 16));
  assign yo    = 4'(py - 32'(TOP_Y));

  // Phase counts from animation start so the first frames show the icon.
  assign blink_el = CNT_LOAD - blink_cnt;
  assign blink_on = ((blink_el / HALF) & CW'(1)) == '0;

  always_comb begin
    icon_gain = 1'b0;
    case (state)
      LOSS_BLINK: icon_vis = (icon_idx < loss_to) || ((icon_idx < loss_from) && blink_on);
`ifdef INDICATIONS_GAIN_FLASH_EN
      GAIN_FLASH: begin
        icon_vis  = icon_idx < life_shown;
        icon_gain = icon_idx >= gain_from;
      end
`endif
      default:    icon_vis = icon_idx < life_shown;
    endcase
  end

  life_icon_rom u_rom (
    .x   (xo),
    .y   (yo),
    .pix (rom_pix)
  );

  assign draw_p0 = x_hit & y_hit & icon_vis & rom_pix;
  assign rgb_p0  = !draw_p0 ? 8'h00 : (icon_gain ? COLOR_GAIN : COLOR_LIFE);

  // ---- stage p0 -> p1: registered pixel outputs ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drawIndications <= 1'b0;
      RGBIndications  <= 8'h00;
    end else begin
      drawIndications <= draw_p0;
      RGBIndications  <= rgb_p0;
    end
  end

  assign animBusy = (state != STEADY);

endmodule

// File: tb/tb_indications_ctrl.sv
// Bench for indications_ctrl: per-scenario tasks against a frame-level reference model.
module tb_indications_ctrl;
  import indications_ctrl_pkg::*;

  localparam int LIFE_MAX = 7, TOP_X = 8, TOP_Y = 8, ICON_GAP = 4;
  localparam int BLINK_FRAMES = 32, BLINK_HALF = 4, PITCH = 16 + ICON_GAP;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] pixelX = 11'd1, pixelY = 11'd0;
  logic [3:0]  life = 4'd3;
  logic        drawIndications;
  logic [7:0]  RGBIndications;
  logic        animBusy;

  int errors = 0, checks = 0;

  // reference model: displayed count, active animations and frames elapsed since start
  int m_shown, m_lo, m_hi, m_glo, m_age;
  bit m_loss, m_gain;

  logic [15:0] heart [16] = '{16'h0000, 16'h1C38, 16'h3E7C, 16'h7FFE, 16'h7FFE, 16'h7FFE,
                              16'h7FFE, 16'h3FFC, 16'h1FF8, 16'h0FF0, 16'h07E0, 16'h03C0,
                              16'h0180, 16'h0000, 16'h0000, 16'h0000};

  always #5 clk = ~clk;

  indications_ctrl #(
    .LIFE_MAX(LIFE_MAX), .TOP_X(TOP_X), .TOP_Y(TOP_Y), .ICON_GAP(ICON_GAP),
    .BLINK_FRAMES(BLINK_FRAMES), .BLINK_HALF(BLINK_HALF)
  ) dut (
    .clk(clk), .reset(reset), .pixelX(pixelX), .pixelY(pixelY), .life(life),
    .drawIndications(drawIndications), .RGBIndications(RGBIndications), .animBusy(animBusy)
  );

  function automatic int clampi(input int v);
    return (v > LIFE_MAX) ? LIFE_MAX : v;
  endfunction

  function automatic void model_reset();
    m_shown = clampi(LIFE_INIT);
    m_loss = 0; m_gain = 0; m_age = 0;
  endfunction

  function automatic void model_gain(input int e, input int base);
    m_shown = e; m_loss = 0;
`ifdef INDICATIONS_GAIN_FLASH_EN
    m_gain = 1; m_glo = base; m_age = 0;
`else
    m_gain = 0; m_glo = base;
`endif
  endfunction

  function automatic void model_loss(input int e);
    m_hi = m_shown; m_lo = e; m_loss = 1; m_gain = 0; m_age = 0;
  endfunction

  function automatic void model_tick(input int l);
    int e;
    e = clampi(l);
    if (m_loss) begin
      if (e < m_lo) begin m_lo = e; m_age = 0; end
      else if (e > m_lo) model_gain(e, m_lo);
      else if (m_age == BLINK_FRAMES - 1) begin m_loss = 0; m_shown = m_lo; end
      else m_age++;
    end else if (m_gain) begin
      if (e < m_shown) model_loss(e);
      else if (e > m_shown) model_gain(e, m_shown);
      else if (m_age == BLINK_FRAMES - 1) m_gain = 0;
      else m_age++;
    end else begin
      if (e < m_shown) model_loss(e);
      else if (e > m_shown) model_gain(e, m_shown);
    end
  endfunction

  function automatic void exp_pix(input int x, input int y, output logic d, output logic [7:0] c);
    int rel, i, xo;
    bit vis;
    d = 1'b0; c = 8'h00; vis = 0;
    if (y >= TOP_Y && y < TOP_Y + 16 && x >= TOP_X) begin
      rel = x - TOP_X; i = rel / PITCH; xo = rel % PITCH;
      if (xo < 16 && i < LIFE_MAX) begin
        if (m_loss) vis = (i < m_lo) || (i < m_hi && ((m_age / BLINK_HALF) % 2 == 0));
        else        vis = (i < m_shown);
        if (vis && heart[y - TOP_Y][15 - xo]) begin
          d = 1'b1;
          c = (m_gain && i >= m_glo) ? COLOR_GAIN : COLOR_LIFE;
        end
      end
    end
  endfunction

  task automatic probe(input int x, input int y, output logic d, output logic [7:0] c);
    @(negedge clk); pixelX = 11'(x); pixelY = 11'(y);
    @(negedge clk); d = drawIndications; c = RGBIndications;
  endtask

  // One frame tick with life l; life is scrambled afterwards since only the tick may sample it.
  task automatic do_tick(input int l);
    @(negedge clk); life = 4'(l); pixelX = 11'd0; pixelY = 11'd0;
    @(negedge clk); pixelX = 11'd1; life = 4'($urandom_range(0, 15));
    model_tick(l);
  endtask

  task automatic test_reset();
    logic d, pd, first;
    logic [7:0] c, pc;
    repeat (3) @(negedge clk);
    checks++; if (drawIndications !== 1'b0) begin errors++; $display("FAIL reset_draw: got %0b want 0", drawIndications); end
    checks++; if (RGBIndications !== 8'h00) begin errors++; $display("FAIL reset_rgb: got %02h want 00", RGBIndications); end
    checks++; if (animBusy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", animBusy); end
    model_reset();
    reset = 1'b0;
    first = 1'b1; pd = 1'b0; pc = 8'h00;
    for (int y = 4; y < 28; y++) begin
      for (int x = 1; x < 160; x++) begin
        @(negedge clk);
        if (!first) begin
          checks++;
          if (drawIndications !== pd || RGBIndications !== pc) begin
            errors++;
            $display("FAIL reset_scan prev of x=%0d y=%0d: got draw=%0b rgb=%02h want draw=%0b rgb=%02h",
                     x, y, drawIndications, RGBIndications, pd, pc);
          end
        end
        exp_pix(x, y, pd, pc);
        pixelX = 11'(x); pixelY = 11'(y); first = 1'b0;
      end
    end
    @(negedge clk);
    checks++; if (drawIndications !== pd || RGBIndications !== pc) begin errors++; $display("FAIL reset_scan last: got draw=%0b rgb=%02h want draw=%0b rgb=%02h", drawIndications, RGBIndications, pd, pc); end
    probe(15, 13, d, c);
    checks++; if (d !== 1'b1 || c !== COLOR_LIFE) begin errors++; $display("FAIL reset_icon0: got draw=%0b rgb=%02h want 1/%02h", d, c, COLOR_LIFE); end
    probe(55, 13, d, c);
    checks++; if (d !== 1'b1 || c !== COLOR_LIFE) begin errors++; $display("FAIL reset_icon2: got draw=%0b rgb=%02h want 1/%02h", d, c, COLOR_LIFE); end
    probe(75, 13, d, c);
    checks++; if (d !== 1'b0 || c !== 8'h00) begin errors++; $display("FAIL reset_icon3: got draw=%0b rgb=%02h want 0/00", d, c); end
    probe(8, 8, d, c);
    checks++; if (d !== 1'b0 || c !== 8'h00) begin errors++; $display("FAIL reset_transparent: got draw=%0b rgb=%02h want 0/00", d, c); end
  endtask

  task automatic test_loss_blink();
    logic d, ed;
    logic [7:0] c, ec;
    int busy;
    busy = 0;
    for (int f = 0; f <= 32; f++) begin
      do_tick(2);
      if (animBusy === 1'b1) busy++;
      for (int i = 0; i < 8; i++) begin
        probe(TOP_X + i * PITCH + 7, TOP_Y + 5, d, c);
        exp_pix(TOP_X + i * PITCH + 7, TOP_Y + 5, ed, ec);
        checks++;
        if (d !== ed || c !== ec) begin errors++; $display("FAIL loss_blink f=%0d icon=%0d: got draw=%0b rgb=%02h want draw=%0b rgb=%02h", f, i, d, c, ed, ec); end
        if (i == 2) begin
          checks++;
          if (d !== ((f < 32) && ((f / 4) % 2 == 0))) begin errors++; $display("FAIL loss_phase f=%0d: got draw=%0b want %0b", f, d, ((f < 32) && ((f / 4) % 2 == 0))); end
        end
      end
    end
    checks++; if (busy != 32) begin errors++; $display("FAIL loss_busy_frames: got %0d want 32", busy); end
    checks++; if (animBusy !== 1'b0) begin errors++; $display("FAIL loss_end_busy: got %0b want 0", animBusy); end
  endtask

  task automatic test_loss_extend();
    logic d, ed;
    logic [7:0] c, ec;
    do_tick(3);
    for (int k = 0; k < 40 && animBusy === 1'b1; k++) do_tick(3);
    checks++; if (animBusy !== 1'b0) begin errors++; $display("FAIL extend_settle: busy=%0b want 0", animBusy); end
    for (int f = 0; f <= 42; f++) begin
      do_tick(f < 10 ? 2 : 1);
      checks++; if (animBusy !== (m_loss || m_gain)) begin errors++; $display("FAIL extend_busy f=%0d: got %0b want %0b", f, animBusy, (m_loss || m_gain)); end
      for (int i = 0; i < 4; i++) begin
        probe(TOP_X + i * PITCH + 7, TOP_Y + 5, d, c);
        exp_pix(TOP_X + i * PITCH + 7, TOP_Y + 5, ed, ec);
        checks++;
        if (d !== ed || c !== ec) begin errors++; $display("FAIL loss_extend f=%0d icon=%0d: got draw=%0b rgb=%02h want draw=%0b rgb=%02h", f, i, d, c, ed, ec); end
        if ((f == 10 || f == 14) && (i == 1 || i == 2)) begin
          checks++;
          if (d !== (f == 10)) begin errors++; $display("FAIL extend_phase f=%0d icon=%0d: got %0b want %0b", f, i, d, (f == 10)); end
        end
      end
    end
    probe(TOP_X + 7, TOP_Y + 5, d, c);
    checks++; if (d !== 1'b1) begin errors++; $display("FAIL extend_icon0: got %0b want 1", d); end
    probe(TOP_X + PITCH + 7, TOP_Y + 5, d, c);
    checks++; if (d !== 1'b0) begin errors++; $display("FAIL extend_icon1: got %0b want 0", d); end
  endtask

  task automatic test_gain();
    logic d, ed;
    logic [7:0] c, ec;
    do_tick(2);
    for (int k = 0; k < 40 && animBusy === 1'b1; k++) do_tick(2);
    checks++; if (animBusy !== 1'b0) begin errors++; $display("FAIL gain_settle: busy=%0b want 0", animBusy); end
    do_tick(5);
    probe(TOP_X + 3 * PITCH + 7, TOP_Y + 5, d, c);
`ifdef INDICATIONS_GAIN_FLASH_EN
    checks++; if (animBusy !== 1'b1) begin errors++; $display("FAIL gain_busy: got %0b want 1", animBusy); end
    checks++; if (d !== 1'b1 || c !== COLOR_GAIN) begin errors++; $display("FAIL gain_icon3: got draw=%0b rgb=%02h want 1/%02h", d, c, COLOR_GAIN); end
`else
    checks++; if (animBusy !== 1'b0) begin errors++; $display("FAIL gain_busy: got %0b want 0", animBusy); end
    checks++; if (d !== 1'b1 || c !== COLOR_LIFE) begin errors++; $display("FAIL gain_icon3: got draw=%0b rgb=%02h want 1/%02h", d, c, COLOR_LIFE); end
`endif
    for (int f = 0; f <= 32; f++) begin
      do_tick(5);
      checks++; if (animBusy !== (m_loss || m_gain)) begin errors++; $display("FAIL gain_busy f=%0d: got %0b want %0b", f, animBusy, (m_loss || m_gain)); end
      for (int i = 0; i < 6; i++) begin
        probe(TOP_X + i * PITCH + 7, TOP_Y + 5, d, c);
        exp_pix(TOP_X + i * PITCH + 7, TOP_Y + 5, ed, ec);
        checks++;
        if (d !== ed || c !== ec) begin errors++; $display("FAIL gain f=%0d icon=%0d: got draw=%0b rgb=%02h want draw=%0b rgb=%02h", f, i, d, c, ed, ec); end
      end
    end
    probe(TOP_X + 3 * PITCH + 7, TOP_Y + 5, d, c);
    checks++; if (d !== 1'b1 || c !== COLOR_LIFE) begin errors++; $display("FAIL gain_after: got draw=%0b rgb=%02h want 1/%02h", d, c, COLOR_LIFE); end
  endtask

  task automatic test_clamp();
    logic d;
    logic [7:0] c;
    do_tick(15);
    for (int k = 0; k < 40 && animBusy === 1'b1; k++) do_tick(15);
    checks++; if (animBusy !== 1'b0) begin errors++; $display("FAIL clamp_settle: busy=%0b want 0", animBusy); end
    probe(TOP_X + 6 * PITCH + 7, TOP_Y + 5, d, c);
    checks++; if (d !== 1'b1 || c !== COLOR_LIFE) begin errors++; $display("FAIL clamp_icon6: got draw=%0b rgb=%02h want 1/%02h", d, c, COLOR_LIFE); end
    probe(TOP_X + 7 * PITCH + 7, TOP_Y + 5, d, c);
    checks++; if (d !== 1'b0) begin errors++; $display("FAIL clamp_icon7: got %0b want 0", d); end
  endtask

  task automatic test_reset_mid();
    logic d, ed;
    logic [7:0] c, ec;
    do_tick(4);
    do_tick(4);
    probe(TOP_X + 7, TOP_Y + 5, d, c);
    checks++; if (d !== 1'b1 || animBusy !== 1'b1) begin errors++; $display("FAIL midreset_pre: got draw=%0b busy=%0b want 1/1", d, animBusy); end
    @(negedge clk); #1 reset = 1'b1;
    #1;
    checks++; if (drawIndications !== 1'b0 || RGBIndications !== 8'h00 || animBusy !== 1'b0) begin
      errors++; $display("FAIL midreset_async: got draw=%0b rgb=%02h busy=%0b want 0/00/0", drawIndications, RGBIndications, animBusy);
    end
    @(negedge clk); reset = 1'b0; life = 4'd1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      probe(TOP_X + i * PITCH + 7, TOP_Y + 5, d, c);
      exp_pix(TOP_X + i * PITCH + 7, TOP_Y + 5, ed, ec);
      checks++;
      if (d !== ed || c !== ec || animBusy !== 1'b0) begin errors++; $display("FAIL midreset_init icon=%0d: got draw=%0b rgb=%02h busy=%0b want draw=%0b rgb=%02h busy=0", i, d, c, animBusy, ed, ec); end
    end
    do_tick(1);
    checks++; if (animBusy !== 1'b1) begin errors++; $display("FAIL midreset_tick: busy=%0b want 1", animBusy); end
  endtask

  task automatic test_random();
    logic d, ed;
    logic [7:0] c, ec;
    int l, x, y;
    l = 1;
    for (int f = 0; f < 150; f++) begin
      if ($urandom_range(0, 3) == 0) l = $urandom_range(0, 15);
      do_tick(l);
      checks++; if (animBusy !== (m_loss || m_gain)) begin errors++; $display("FAIL random_busy f=%0d: got %0b want %0b", f, animBusy, (m_loss || m_gain)); end
      for (int i = 0; i < 12; i++) begin
        if (i < 8) begin x = TOP_X + i * PITCH + 7; y = TOP_Y + 5; end
        else begin
          x = $urandom_range(0, 170); y = $urandom_range(0, 30);
          if (x == 0 && y == 0) x = 1;
        end
        probe(x, y, d, c);
        exp_pix(x, y, ed, ec);
        checks++;
        if (d !== ed || c !== ec) begin errors++; $display("FAIL random f=%0d x=%0d y=%0d: got draw=%0b rgb=%02h want draw=%0b rgb=%02h", f, x, y, d, c, ed, ec); end
      end
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_loss_blink();
    test_loss_extend();
    test_gain();
    test_clamp();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
